// File: rtl/rx_pack.sv
// rx_pack: packs pairs of 4-bit nibbles into bytes and queues them in a
// small circular FIFO that feeds a byte-wide valid/ready sink.
//
// Ports:
//   clk, rst        - single clock, asynchronous active-high reset
//   valid_i, data_i - upstream nibble handshake (data_i is 4 bits)
//   ready_o         - nibble accept; no combinational path from byte_ready_i
//   flush_i         - discards a partially assembled byte
//   byte_valid_o    - a byte is available at the FIFO head
//   byte_o          - FIFO head byte; 8'h00 when byte_valid_o is low
//   byte_ready_i    - downstream byte accept
//   count_o         - FIFO occupancy, 0..DEPTH
//   drop_o          - one-cycle pulse after a flush discarded a held nibble
module rx_pack #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          LSN_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [3:0]                data_i,
  output logic                      ready_o,
  input  logic                      flush_i,
  output logic                      byte_valid_o,
  output logic [7:0]                byte_o,
  input  logic                      byte_ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_LOW,
    S_HIGH
  } state_t;

  state_t          state_q;
  logic [3:0]      nib_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            drop_q;
  logic [7:0]      mem [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic [7:0]      packed_byte;

  // The first nibble may be taken even when full; only the completing
  // nibble needs FIFO space. A same-cycle pop never opens space.
  assign ready_o     = !flush_i && ((state_q == S_LOW) || (count_q < CW'(DEPTH)));
  assign accept      = valid_i && ready_o;
  assign push        = accept && (state_q == S_HIGH);
  assign pop         = byte_valid_o && byte_ready_i;
  assign packed_byte = LSN_FIRST ? {data_i, nib_q} : {nib_q, data_i};

  assign byte_valid_o = (count_q != '0);
  assign byte_o       = byte_valid_o ? mem[rd_ptr_q] : 8'h00;
  assign count_o      = count_q;
  assign drop_o       = drop_q;

  // Pack FSM, FIFO pointers, occupancy counter and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOW;
      nib_q    <= 4'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= flush_i && (state_q == S_HIGH);

      if (flush_i) begin
        state_q <= S_LOW;
        nib_q   <= 4'h0;
      end else if (accept) begin
        case (state_q)
          S_LOW: begin
            nib_q   <= data_i;
            state_q <= S_HIGH;
          end
          default: begin
            state_q <= S_LOW;
          end
        endcase
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Byte storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= packed_byte;
    end
  end

endmodule
